// File: rtl/rotator_arbiter.sv
// Round-robin (or fixed-priority) arbiter sharing one external 4-bit left rotator
// between two command ports, returning each result on a tagged response handshake.
module rotator_arbiter #(
   parameter bit FAIR = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic [3:0] req0_data,
   input  logic [1:0] req0_amt,
   input  logic       req0_dir,
   input  logic       req1_valid,
   output logic       req1_ready,
   input  logic [3:0] req1_data,
   input  logic [1:0] req1_amt,
   input  logic       req1_dir,
   output logic [3:0] rot_data,
   output logic [1:0] rot_select,
   input  logic [3:0] rot_out,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [3:0] rsp_data,
   output logic       rsp_id
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t     state;
   logic       last_grant;
   logic       grant1;
   logic       accept;
   logic [3:0] win_data;
   logic [1:0] win_amt;
   logic       win_dir;
   logic [1:0] win_select;

   // NOTE: every signal assigned here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      grant1 = 1'b0;
      if (req1_valid && !req0_valid)
         grant1 = 1'b1;
      else if (req1_valid && req0_valid && FAIR && !last_grant)
         grant1 = 1'b1;

      // Ready is offered only in IDLE and is forced low while reset is held.
      req0_ready = (state == IDLE) && !reset && req0_valid && !grant1;
      req1_ready = (state == IDLE) && !reset && grant1;
      accept     = req0_ready || req1_ready;

      win_data = grant1 ? req1_data : req0_data;
      win_amt  = grant1 ? req1_amt  : req0_amt;
      win_dir  = grant1 ? req1_dir  : req0_dir;

      // A right rotate by n equals a left rotate by (4 - n) mod 4.
      win_select = win_dir ? (2'd0 - win_amt) : win_amt;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         rot_data   <= '0;
         rot_select <= '0;
         rsp_valid  <= 1'b0;
         rsp_data   <= '0;
         rsp_id     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  rot_data   <= win_data;
                  rot_select <= win_select;
                  rsp_id     <= grant1;
                  state      <= EXEC;
               end
            end
            EXEC: begin
               rsp_data  <= rot_out;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid  <= 1'b0;
                  last_grant <= rsp_id;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rotator_arbiter.sv
// Directed bench for rotator_arbiter: a FAIR=1 instance for most steps and a
// FAIR=0 instance for the fixed-priority sequence; the rotator is modelled here.
module tb_rotator_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   int         n_tests = 0;
   int         n_fail  = 0;

   logic       req0_valid, req0_ready, req0_dir, req1_valid, req1_ready, req1_dir;
   logic [3:0] req0_data, req1_data, rot_data, rot_out, rsp_data;
   logic [1:0] req0_amt, req1_amt, rot_select;
   logic       rsp_valid, rsp_ready, rsp_id;

   logic       f_req0_valid, f_req0_ready, f_req0_dir, f_req1_valid, f_req1_ready, f_req1_dir;
   logic [3:0] f_req0_data, f_req1_data, f_rot_data, f_rot_out, f_rsp_data;
   logic [1:0] f_req0_amt, f_req1_amt, f_rot_select;
   logic       f_rsp_valid, f_rsp_ready, f_rsp_id;

   always #5 clk = ~clk;

   function automatic logic [3:0] rotl(input logic [3:0] d, input logic [1:0] s);
      logic [7:0] dd;
      dd = {d, d} << s;
      return dd[7:4];
   endfunction

   assign rot_out   = rotl(rot_data, rot_select);
   assign f_rot_out = rotl(f_rot_data, f_rot_select);

   rotator_arbiter #(.FAIR(1'b1)) u_dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
      .req0_amt(req0_amt), .req0_dir(req0_dir),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
      .req1_amt(req1_amt), .req1_dir(req1_dir),
      .rot_data(rot_data), .rot_select(rot_select), .rot_out(rot_out),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id)
   );

   rotator_arbiter #(.FAIR(1'b0)) u_fix (
      .clk(clk), .reset(reset),
      .req0_valid(f_req0_valid), .req0_ready(f_req0_ready), .req0_data(f_req0_data),
      .req0_amt(f_req0_amt), .req0_dir(f_req0_dir),
      .req1_valid(f_req1_valid), .req1_ready(f_req1_ready), .req1_data(f_req1_data),
      .req1_amt(f_req1_amt), .req1_dir(f_req1_dir),
      .rot_data(f_rot_data), .rot_select(f_rot_select), .rot_out(f_rot_out),
      .rsp_valid(f_rsp_valid), .rsp_ready(f_rsp_ready), .rsp_data(f_rsp_data), .rsp_id(f_rsp_id)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_rsp(input string tag);
      int n = 0;
      while (!rsp_valid && n < 10) begin
         cyc();
         n++;
      end
      check({tag, "_rsp_timeout"}, {7'd0, rsp_valid}, 8'd1);
   endtask

   // One command on one port with exact-latency checks; ends back in IDLE.
   task automatic do_cmd(input int port, input logic [3:0] d, input logic [1:0] a,
                         input logic dr, input logic [1:0] esel, input logic [3:0] eres,
                         input string tag);
      if (port == 0) begin
         req0_data = d; req0_amt = a; req0_dir = dr; req0_valid = 1'b1;
      end else begin
         req1_data = d; req1_amt = a; req1_dir = dr; req1_valid = 1'b1;
      end
      #1;
      check({tag, "_ready0"}, {7'd0, req0_ready}, (port == 0) ? 8'd1 : 8'd0);
      check({tag, "_ready1"}, {7'd0, req1_ready}, (port == 1) ? 8'd1 : 8'd0);
      cyc();
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_data  = ~d;   req1_data  = ~d;
      check({tag, "_rot_select"}, {6'd0, rot_select}, {6'd0, esel});
      check({tag, "_rot_data"}, {4'd0, rot_data}, {4'd0, d});
      check({tag, "_valid_early"}, {7'd0, rsp_valid}, 8'd0);
      cyc();
      check({tag, "_valid"}, {7'd0, rsp_valid}, 8'd1);
      check({tag, "_data"}, {4'd0, rsp_data}, {4'd0, eres});
      check({tag, "_id"}, {7'd0, rsp_id}, port[7:0]);
      rsp_ready = 1'b1;
      cyc();
      check({tag, "_valid_drop"}, {7'd0, rsp_valid}, 8'd0);
      rsp_ready = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      req0_valid = 1'b1; req0_data = '0; req0_amt = '0; req0_dir = 1'b0;
      req1_valid = 1'b1; req1_data = '0; req1_amt = '0; req1_dir = 1'b0;
      rsp_ready = 1'b0;
      f_req0_valid = 1'b0; f_req0_data = '0; f_req0_amt = '0; f_req0_dir = 1'b0;
      f_req1_valid = 1'b0; f_req1_data = '0; f_req1_amt = '0; f_req1_dir = 1'b0;
      f_rsp_ready = 1'b0;

      // Reset state, with both requesters valid.
      cyc();
      check("rst_ready0", {7'd0, req0_ready}, 8'd0);
      check("rst_ready1", {7'd0, req1_ready}, 8'd0);
      check("rst_rsp_valid", {7'd0, rsp_valid}, 8'd0);
      check("rst_rsp_data", {4'd0, rsp_data}, 8'd0);
      check("rst_rot_select", {6'd0, rot_select}, 8'd0);
      req0_valid = 1'b0; req1_valid = 1'b0;
      reset = 1'b0;
      cyc();

      do_cmd(0, 4'b1011, 2'd1, 1'b0, 2'd1, 4'b0111, "left1");
      do_cmd(1, 4'b1011, 2'd1, 1'b1, 2'd3, 4'b1101, "right1");
      do_cmd(1, 4'b1000, 2'd2, 1'b1, 2'd2, 4'b0010, "right2");
      do_cmd(0, 4'b0110, 2'd0, 1'b0, 2'd0, 4'b0110, "left0");
      do_cmd(0, 4'b0110, 2'd0, 1'b1, 2'd0, 4'b0110, "right0");

      // Round-robin from a fresh reset: grants 0,1,0,1.
      reset = 1'b1; #1; reset = 1'b0;
      req0_data = 4'b0001; req0_amt = 2'd1; req0_dir = 1'b0; req0_valid = 1'b1;
      req1_data = 4'b0001; req1_amt = 2'd2; req1_dir = 1'b0; req1_valid = 1'b1;
      rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_rsp($sformatf("rr%0d", i));
         check($sformatf("rr%0d_id", i), {7'd0, rsp_id}, (i % 2 == 0) ? 8'd0 : 8'd1);
         check($sformatf("rr%0d_data", i), {4'd0, rsp_data}, (i % 2 == 0) ? 8'h2 : 8'h4);
         cyc();
      end
      req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
      cyc();

      // Back-pressure: port 0 right-by-3 of 1100 -> 1001; both ports valid meanwhile.
      req0_data = 4'b1100; req0_amt = 2'd3; req0_dir = 1'b1; req0_valid = 1'b1;
      cyc();
      req1_data = 4'b0011; req1_amt = 2'd1; req1_dir = 1'b0; req1_valid = 1'b1;
      wait_rsp("bp");
      for (int i = 0; i < 5; i++) begin
         check($sformatf("bp%0d_valid", i), {7'd0, rsp_valid}, 8'd1);
         check($sformatf("bp%0d_data", i), {4'd0, rsp_data}, 8'h9);
         check($sformatf("bp%0d_id", i), {7'd0, rsp_id}, 8'd0);
         check($sformatf("bp%0d_readys", i), {6'd0, req1_ready, req0_ready}, 8'd0);
         cyc();
      end
      rsp_ready = 1'b1;
      #1;
      check("bp_hs_readys", {6'd0, req1_ready, req0_ready}, 8'd0);
      cyc();
      rsp_ready = 1'b0;
      check("bp_after_valid", {7'd0, rsp_valid}, 8'd0);
      check("bp_after_ready1", {7'd0, req1_ready}, 8'd1);
      check("bp_after_ready0", {7'd0, req0_ready}, 8'd0);
      req0_valid = 1'b0; req1_valid = 1'b0;
      cyc();

      // Reset while holding a response in RESP.
      req1_data = 4'b0101; req1_amt = 2'd1; req1_dir = 1'b0; req1_valid = 1'b1;
      cyc();
      req1_valid = 1'b0;
      wait_rsp("rstresp");
      req1_valid = 1'b1;
      reset = 1'b1;
      #1;
      check("rstresp_valid", {7'd0, rsp_valid}, 8'd0);
      check("rstresp_data", {4'd0, rsp_data}, 8'd0);
      check("rstresp_rot_data", {4'd0, rot_data}, 8'd0);
      check("rstresp_ready1", {7'd0, req1_ready}, 8'd0);
      req0_valid = 1'b1;
      reset = 1'b0;
      #1;
      check("rstresp_tie0", {7'd0, req0_ready}, 8'd1);
      check("rstresp_tie1", {7'd0, req1_ready}, 8'd0);
      req0_valid = 1'b0; req1_valid = 1'b0;
      cyc();
      cyc();
      check("rstresp_no_rsp", {7'd0, rsp_valid}, 8'd0);

      // Fixed priority: port 0 wins every tie while it stays valid.
      f_req0_data = 4'b0001; f_req0_amt = 2'd0; f_req0_dir = 1'b0; f_req0_valid = 1'b1;
      f_req1_data = 4'b0001; f_req1_amt = 2'd3; f_req1_dir = 1'b0; f_req1_valid = 1'b1;
      f_rsp_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         int n = 0;
         if (i == 4) f_req0_valid = 1'b0;
         while (!f_rsp_valid && n < 10) begin
            cyc();
            n++;
         end
         check($sformatf("fix%0d_valid", i), {7'd0, f_rsp_valid}, 8'd1);
         check($sformatf("fix%0d_id", i), {7'd0, f_rsp_id}, (i == 4) ? 8'd1 : 8'd0);
         check($sformatf("fix%0d_data", i), {4'd0, f_rsp_data}, (i == 4) ? 8'h8 : 8'h1);
         cyc();
      end
      f_req0_valid = 1'b0; f_req1_valid = 1'b0; f_rsp_ready = 1'b0;
      cyc();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
